// File: rtl/fifo_block_reader.sv
// fifo_block_reader: pops a block of words from a FWFT FIFO with optional random throttling,
// tracking word count and checksum, and aborting when the FIFO starves for too long.
// Optional feature: define FIFO_BLOCK_READER_THROTTLE_EN to enable the LFSR read throttle.
module fifo_block_reader #(
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_BLOCK_SIZE = 128,
    parameter int TIMEOUT        = 10000,
    localparam int LEN_W         = $clog2(MAX_BLOCK_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    input  logic [7:0]            rate,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [LEN_W-1:0]      word_count,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, READ, DONE, ABORT} state_t;

    state_t state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [TO_W-1:0] to_cnt;
    logic throttle_ok;
    logic pop;
    logic last_pop;
    logic accept;

`ifdef FIFO_BLOCK_READER_THROTTLE_EN
    logic [15:0] lfsr;
    // Free-running Fibonacci LFSR, taps 16,14,13,11, shifting right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign throttle_ok = (rate == 8'hFF) || (lfsr[7:0] < rate);
`else
    logic unused_rate;
    assign unused_rate = ^rate;
    assign throttle_ok = 1'b1;
`endif

    assign pop      = rd_en;
    assign accept   = (state == IDLE) && start;
    assign last_pop = pop && ((word_count + LEN_W'(1)) == len_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: zero-length blocks complete immediately, starvation aborts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ((length == '0) ? DONE : READ) : IDLE;
            READ:    state_nxt = last_pop ? DONE : ((!pop && to_cnt == TO_LAST) ? ABORT : READ);
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; pops only when data is present and throttle allows
    always_comb begin
        rd_en = (state == READ) && !empty && throttle_ok;
        busy  = (state != IDLE);
        done  = (state == DONE) || (state == ABORT);
    end

    // Latch the clamped block length on an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            len_q <= '0;
        else if (accept)
            len_q <= (length > MAX_LEN) ? MAX_LEN : length;
    end

    // Count words and accumulate checksum; values hold in IDLE until the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (accept) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (pop) begin
            word_count <= word_count + LEN_W'(1);
            checksum   <= checksum + din;
        end
    end

    // Starvation counter: runs on READ cycles without a pop, cleared by each pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (accept || pop)
            to_cnt <= '0;
        else if (state == READ)
            to_cnt <= to_cnt + TO_W'(1);
    end

    // Sticky abort flag, set entering ABORT and cleared by the next accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timeout_err <= 1'b0;
        else if (accept)
            timeout_err <= 1'b0;
        else if (state == READ && state_nxt == ABORT)
            timeout_err <= 1'b1;
    end

    // Register each popped word one cycle after the pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= pop;
            if (pop)
                data_o <= din;
        end
    end
endmodule
